// File: rtl/spi_tx_arbiter.sv
// Round-robin, burst-locked arbiter that shares the core2spi FIFO write port among N_PORTS requesters.
// Optional stall watchdog on a locked burst is enabled by defining SPI_ARB_WATCHDOG_EN.
module spi_tx_arbiter #(
    parameter int N_PORTS = 4,
    parameter int HP_PORT = 0,
    parameter int TIMEOUT = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic [N_PORTS-1:0]     req_valid_i,
    input  logic [32*N_PORTS-1:0]  req_data_i,
    input  logic [N_PORTS-1:0]     req_last_i,
    output logic [N_PORTS-1:0]     req_ready_o,
    input  logic                   fifo_full_i,
    input  logic                   fifo_urgent_i,
    output logic                   wr_en_o,
    output logic [31:0]            wr_din_o,
    output logic [2:0]             grant_idx_o,
    output logic                   busy_o,
    output logic                   err_timeout_o
);

    typedef enum logic {
        ST_IDLE,
        ST_LOCK
    } state_t;

    state_t          state_q, state_d;
    logic [2:0]      grant_q, grant_d;
    logic [2:0]      rr_ptr_q, rr_ptr_d;
    logic            wr_en_q, wr_en_d;
    logic [31:0]     wr_din_q, wr_din_d;

    logic [7:0]       valid8;
    logic [7:0]       last8;
    logic [7:0]       elig8;
    logic [7:0][31:0] data8;
    logic [2:0]       pick;
    logic [2:0]       cand;
    logic             found;
    logic [2:0]       grant_next;
    logic             accept;

    // Requester vectors are widened to 8 entries so the 3-bit grant index can select directly.
    assign valid8 = 8'(req_valid_i);
    assign last8  = 8'(req_last_i);

    for (genvar i = 0; i < 8; i++) begin : g_pad
        if (i < N_PORTS) begin : g_on
            assign data8[i] = req_data_i[32*i +: 32];
        end else begin : g_off
            assign data8[i] = '0;
        end
    end

    // While the FIFO is near full only the high-priority port may start a new burst.
    assign elig8 = fifo_urgent_i ? (valid8 & (8'd1 << HP_PORT)) : valid8;

    always_comb begin
        found = 1'b0;
        pick  = rr_ptr_q;
        cand  = rr_ptr_q;
        for (int k = 0; k < N_PORTS; k++) begin
            cand = 3'((int'(rr_ptr_q) + k) % N_PORTS);
            if (!found && elig8[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    assign grant_next = (grant_q == 3'(N_PORTS - 1)) ? 3'd0 : grant_q + 3'd1;
    assign accept     = (state_q == ST_LOCK) && valid8[grant_q] && !fifo_full_i;

`ifdef SPI_ARB_WATCHDOG_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    logic [STALL_W-1:0] stall_q, stall_d;
    logic               err_q, err_d;
`endif

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        wr_en_d  = 1'b0;
        wr_din_d = wr_din_q;
`ifdef SPI_ARB_WATCHDOG_EN
        stall_d  = '0;
        err_d    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (found) begin
                    grant_d = pick;
                    state_d = ST_LOCK;
                end
            end
            ST_LOCK: begin
`ifdef SPI_ARB_WATCHDOG_EN
                stall_d = stall_q;
`endif
                if (accept) begin
                    wr_en_d  = 1'b1;
                    wr_din_d = data8[grant_q];
                    if (last8[grant_q]) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_next;
                    end
`ifdef SPI_ARB_WATCHDOG_EN
                    stall_d = '0;
                end else if (!valid8[grant_q]) begin
                    // Only an absent requester counts as a stall; FIFO backpressure does not.
                    if (stall_q == STALL_W'(TIMEOUT - 1)) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = grant_next;
                        err_d    = 1'b1;
                        stall_d  = '0;
                    end else begin
                        stall_d = stall_q + STALL_W'(1);
                    end
`endif
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
            wr_en_q  <= 1'b0;
            wr_din_q <= '0;
`ifdef SPI_ARB_WATCHDOG_EN
            stall_q  <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            wr_en_q  <= wr_en_d;
            wr_din_q <= wr_din_d;
`ifdef SPI_ARB_WATCHDOG_EN
            stall_q  <= stall_d;
            err_q    <= err_d;
`endif
        end
    end

    assign req_ready_o = ((state_q == ST_LOCK) && !fifo_full_i) ? (N_PORTS'(1) << grant_q) : '0;
    assign wr_en_o     = wr_en_q;
    assign wr_din_o    = wr_din_q;
    assign grant_idx_o = grant_q;
    assign busy_o      = (state_q == ST_LOCK);

`ifdef SPI_ARB_WATCHDOG_EN
    assign err_timeout_o = err_q;
`else
    wire unused_timeout = (TIMEOUT != 0);
    assign err_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_spi_tx_arbiter.sv
// Scoreboard bench for spi_tx_arbiter: per-port expected word queues plus a transaction-level
// round-robin/burst-lock model checked by an independent monitor.
module tb_spi_tx_arbiter;

    localparam int N          = 4;
    localparam int HP         = 0;
    localparam int TB_TIMEOUT = 8;

    logic             clk = 1'b0;
    logic             rst;
    logic [N-1:0]     req_valid;
    logic [32*N-1:0]  req_data;
    logic [N-1:0]     req_last;
    logic [N-1:0]     req_ready;
    logic             fifo_full;
    logic             fifo_urgent;
    logic             wr_en;
    logic [31:0]      wr_din;
    logic [2:0]       grant_idx;
    logic             busy;
    logic             err_timeout;

    always #5 clk = ~clk;

    spi_tx_arbiter #(
        .N_PORTS (N),
        .HP_PORT (HP),
        .TIMEOUT (TB_TIMEOUT)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .req_valid_i   (req_valid),
        .req_data_i    (req_data),
        .req_last_i    (req_last),
        .req_ready_o   (req_ready),
        .fifo_full_i   (fifo_full),
        .fifo_urgent_i (fifo_urgent),
        .wr_en_o       (wr_en),
        .wr_din_o      (wr_din),
        .grant_idx_o   (grant_idx),
        .busy_o        (busy),
        .err_timeout_o (err_timeout)
    );

    typedef struct {
        logic [31:0] d;
        bit          last;
        int          gap;
    } stim_t;

    typedef struct {
        logic [31:0] d;
        bit          last;
    } exp_t;

    stim_t stim_q [N][$];
    exp_t  exp_q  [N][$];
    int    owner_log [$];

    int n_chk  = 0;
    int n_fail = 0;

    // Monitor-side model state
    bit           acc_prev;
    int           acc_port_prev;
    bit           acc_in_burst;
    int           acc_owner;
    int           rr_m;
    logic [N-1:0] v_snap;
    logic [N-1:0] accv;
    logic [N-1:0] elig;
    logic [N-1:0] exp_ready;
    int           stall;
    int           err_seen;
    exp_t         e;
    bit           rr_bad;
    int           q;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, req);
        end
    endtask

    task automatic push_word(input int p, input logic [31:0] d, input bit last, input int gap);
        stim_t s;
        exp_t  x;
        s.d = d; s.last = last; s.gap = gap;
        x.d = d; x.last = last;
        stim_q[p].push_back(s);
        exp_q[p].push_back(x);
    endtask

    function automatic bit all_empty();
        for (int p = 0; p < N; p++)
            if (stim_q[p].size() != 0 || exp_q[p].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    // One clock: observe handshakes mid-cycle, then update drivers just after the edge.
    task automatic step();
        logic [N-1:0] acc;
        @(negedge clk);
        acc = req_valid & req_ready;
        @(posedge clk);
        #1;
        for (int p = 0; p < N; p++) begin
            if (acc[p] && stim_q[p].size() > 0) void'(stim_q[p].pop_front());
            if (stim_q[p].size() == 0) begin
                req_valid[p] = 1'b0;
                req_last[p]  = 1'b0;
            end else if (stim_q[p][0].gap > 0) begin
                stim_q[p][0].gap = stim_q[p][0].gap - 1;
                req_valid[p] = 1'b0;
                req_last[p]  = 1'b0;
            end else begin
                req_valid[p]         = 1'b1;
                req_data[32*p +: 32] = stim_q[p][0].d;
                req_last[p]          = stim_q[p][0].last;
            end
        end
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while ((!all_empty() || busy) && c < budget) begin
            step();
            c++;
        end
        if (c >= budget) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s_drain: actual=not drained after %0d cycles required=drained", name, budget);
        end
        step();
        step();
    endtask

    task automatic check_order(input string name, input int exp_ord[$]);
        check({name, "_bursts"}, 32'(owner_log.size()), 32'(exp_ord.size()));
        for (int i = 0; i < exp_ord.size(); i++)
            if (i < owner_log.size()) check({name, "_owner"}, 32'(owner_log[i]), 32'(exp_ord[i]));
        owner_log.delete();
    endtask

    always @(negedge clk) begin
        if (rst) begin
            acc_prev     = 1'b0;
            acc_in_burst = 1'b0;
            rr_m         = 0;
            v_snap       = '0;
            stall        = 0;
        end else begin
            check("wr_en", 32'(wr_en), 32'(acc_prev));
            if (wr_en) begin
                if (exp_q[acc_port_prev].size() == 0) begin
                    n_chk++;
                    n_fail++;
                    $display("FAIL wr_unexpected: actual=write 0x%08h required=no write", wr_din);
                end else begin
                    e = exp_q[acc_port_prev].pop_front();
                    check("wr_din", wr_din, e.d);
                end
            end

            exp_ready = (busy && !fifo_full) ? (N'(1) << grant_idx) : '0;
            check("req_ready", 32'(req_ready), 32'(exp_ready));

            elig = fifo_urgent ? (req_valid & (N'(1) << HP)) : req_valid;
`ifdef SPI_ARB_WATCHDOG_EN
            if (err_timeout) begin
                check("timeout_stall_cycles", 32'(stall), 32'(TB_TIMEOUT));
                err_seen++;
                acc_in_burst = 1'b0;
                rr_m         = (acc_owner + 1) % N;
                v_snap       = elig & ~(N'(1) << acc_owner);
            end
            if (busy && !(|(req_valid & (N'(1) << grant_idx)))) stall++;
            else stall = 0;
`else
            check("err_timeout", 32'(err_timeout), 32'd0);
`endif

            accv     = req_valid & req_ready;
            acc_prev = |accv;
            for (int p = 0; p < N; p++) begin
                if (accv[p]) begin
                    acc_port_prev = p;
                    if (!acc_in_burst) begin
                        // New burst: no port waiting at the last release may sit ahead of p in RR order.
                        rr_bad = 1'b0;
                        for (int k = 0; k < N; k++) begin
                            q = (rr_m + k) % N;
                            if (q == p) break;
                            if (|(v_snap & (N'(1) << q))) rr_bad = 1'b1;
                        end
                        check("rr_grant_port", 32'(rr_bad ? 99 : p), 32'(p));
                        owner_log.push_back(p);
                        acc_in_burst = 1'b1;
                        acc_owner    = p;
                    end else begin
                        check("burst_contiguous", 32'(p), 32'(acc_owner));
                    end
                    if (req_last[p]) begin
                        acc_in_burst = 1'b0;
                        rr_m         = (p + 1) % N;
                        v_snap       = elig & ~(N'(1) << p);
                    end
                end
            end
        end
    end

    initial begin
        int ord[$];
        int len;
        int c;
        rst         = 1'b1;
        req_valid   = '0;
        req_data    = '0;
        req_last    = '0;
        fifo_full   = 1'b0;
        fifo_urgent = 1'b0;
        err_seen    = 0;
        acc_port_prev = 0;
        acc_owner   = 0;

        repeat (3) step();
        rst = 1'b0;
        check("rst_busy",      32'(busy),        32'd0);
        check("rst_wr_en",     32'(wr_en),       32'd0);
        check("rst_wr_din",    wr_din,           32'd0);
        check("rst_ready",     32'(req_ready),   32'd0);
        check("rst_grant",     32'(grant_idx),   32'd0);
        check("rst_err",       32'(err_timeout), 32'd0);

        repeat (20) step();
        check("idle_busy",  32'(busy),      32'd0);
        check("idle_ready", 32'(req_ready), 32'd0);
        check("idle_wr_en", 32'(wr_en),     32'd0);

        // Three simultaneous single-word requests, then a late fourth
        push_word(0, 32'hA000_0000, 1'b1, 0);
        push_word(1, 32'hA100_0001, 1'b1, 0);
        push_word(2, 32'hA200_0002, 1'b1, 0);
        push_word(3, 32'hA300_0003, 1'b1, 2);
        drain("t_single", 200);
        ord = '{0, 1, 2, 3};
        check_order("t_single", ord);

        // Three-word burst from P1 with P2 waiting
        push_word(1, 32'h1000_0001, 1'b0, 0);
        push_word(1, 32'h1000_0002, 1'b0, 0);
        push_word(1, 32'h1000_0003, 1'b1, 0);
        push_word(2, 32'h2000_00AA, 1'b1, 0);
        drain("t_burst", 200);
        ord = '{1, 2};
        check_order("t_burst", ord);

        // FIFO full for 5 cycles in the middle of a burst
        for (int i = 0; i < 4; i++) push_word(0, 32'hF000_0000 + 32'(i), (i == 3), 0);
        c = 0;
        while (exp_q[0].size() > 3 && c < 50) begin step(); c++; end
        check("t_full_first_word", 32'(exp_q[0].size()), 32'd3);
        fifo_full = 1'b1;
        repeat (5) step();
        check("t_full_held", 32'(exp_q[0].size()), 32'd2);
        fifo_full = 1'b0;
        drain("t_full", 200);
        ord = '{0};
        check_order("t_full", ord);

        // Urgent: only the high-priority port may be granted
        fifo_urgent = 1'b1;
        push_word(0, 32'hC000_0000, 1'b1, 0);
        push_word(2, 32'hC200_0002, 1'b1, 0);
        c = 0;
        while (exp_q[0].size() > 0 && c < 50) begin step(); c++; end
        for (int i = 0; i < 6; i++) begin
            step();
            check("t_urgent_idle", 32'(busy), 32'd0);
        end
        check("t_urgent_p2_pending", 32'(exp_q[2].size()), 32'd1);
        fifo_urgent = 1'b0;
        drain("t_urgent", 200);
        ord = '{0, 2};
        check_order("t_urgent", ord);

`ifdef SPI_ARB_WATCHDOG_EN
        // P2 abandons its burst; watchdog releases the lock and P3 follows
        push_word(2, 32'hD200_0001, 1'b0, 0);
        push_word(2, 32'hD200_0002, 1'b0, 0);
        push_word(3, 32'hD300_0003, 1'b1, 3);
        drain("t_watchdog", 300);
        check("t_watchdog_pulses", 32'(err_seen), 32'd1);
        ord = '{2, 3};
        check_order("t_watchdog", ord);
`endif

        // Randomized bursts under random backpressure
        for (int p = 0; p < N; p++) begin
            for (int b = 0; b < 15; b++) begin
                len = int'($urandom_range(1, 4));
                for (int w = 0; w < len; w++)
                    push_word(p, $urandom, (w == len - 1), (w == 0) ? int'($urandom_range(0, 6)) : 0);
            end
        end
        c = 0;
        while (!all_empty() && c < 20000) begin
            fifo_full = ($urandom_range(0, 3) == 0);
            step();
            c++;
        end
        fifo_full = 1'b0;
        drain("t_random", 500);
        for (int p = 0; p < N; p++)
            check("final_exp_empty", 32'(exp_q[p].size()), 32'd0);
        owner_log.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
